// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Parametrised UART transmitter (data bits, parity, stop bits) with
//           ready/valid accept; optional input FIFO under UART_TX_FIFO_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_tx_dv,
    input  logic [DATA_BITS-1:0] i_tx_byte,
    output logic                 o_tx_ready,
    output logic                 o_tx_active,
    output logic                 o_tx_serial,
    output logic                 o_tx_done
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 1 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("uart_tx_cfg: parameter out of range");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state,   w_state_nxt;
    logic [c_CNT_W-1:0]     r_clk_cnt, w_clk_nxt;
    logic [c_IDX_W-1:0]     r_bit_idx, w_idx_nxt;
    logic                   r_stop_cnt, w_stop_nxt;
    logic [DATA_BITS-1:0]   r_data,    w_data_nxt;
    logic [DATA_BITS-1:0]   r_shift,   w_shift_nxt;
    logic                   r_serial,  w_serial_nxt;
    logic                   r_active,  w_active_nxt;
    logic                   r_done,    w_done_nxt;

    logic                   w_ready;
    logic                   w_start;
    logic [DATA_BITS-1:0]   w_byte;
    logic                   w_bit_end;
    logic                   w_par;

`ifdef UART_TX_FIFO_EN
    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW-1:0] c_PTR_LAST = c_AW'(FIFO_DEPTH - 1);
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;
    logic                 w_wr;

    function automatic logic [c_AW-1:0] f_inc(input logic [c_AW-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_ready = (r_count != c_FULL);
    assign w_wr    = i_tx_dv && w_ready;
    // The engine pops the head whenever it is idle; a byte needs one edge to land first.
    assign w_start = (r_state == S_IDLE) && (r_count != '0);
    assign w_byte  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_tx_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_start) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            case ({w_wr, w_start})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign w_ready = (r_state == S_IDLE);
    assign w_start = i_tx_dv && w_ready;
    assign w_byte  = i_tx_byte;
`endif

    assign w_bit_end = (r_clk_cnt == c_CNT_LAST);
    assign w_par     = (PARITY == 1) ? ~^r_data : ^r_data;

    always_comb begin
        w_state_nxt  = r_state;
        w_clk_nxt    = r_clk_cnt;
        w_idx_nxt    = r_bit_idx;
        w_stop_nxt   = r_stop_cnt;
        w_data_nxt   = r_data;
        w_shift_nxt  = r_shift;
        w_serial_nxt = r_serial;
        w_active_nxt = r_active;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_serial_nxt = 1'b1;
                w_active_nxt = 1'b0;
                w_clk_nxt    = '0;
                w_idx_nxt    = '0;
                w_stop_nxt   = 1'b0;
                if (w_start) begin
                    w_data_nxt   = w_byte;
                    w_shift_nxt  = w_byte;
                    w_state_nxt  = S_START;
                    w_serial_nxt = 1'b0;
                    w_active_nxt = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_nxt    = '0;
                    w_state_nxt  = S_DATA;
                    w_serial_nxt = r_shift[0];
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_nxt = '0;
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_idx_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt  = S_PARITY;
                            w_serial_nxt = w_par;
                        end else begin
                            w_state_nxt  = S_STOP;
                            w_serial_nxt = 1'b1;
                        end
                    end else begin
                        w_idx_nxt    = r_bit_idx + 1'b1;
                        w_shift_nxt  = r_shift >> 1;
                        w_serial_nxt = r_shift[1];
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_clk_nxt    = '0;
                    w_state_nxt  = S_STOP;
                    w_serial_nxt = 1'b1;
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_clk_nxt = '0;
                    if (r_stop_cnt == c_STOP_LAST) begin
                        // Land in IDLE with done high so the next accept can share this cycle.
                        w_stop_nxt   = 1'b0;
                        w_state_nxt  = S_IDLE;
                        w_done_nxt   = 1'b1;
                        w_active_nxt = 1'b0;
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end else begin
                    w_clk_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_clk_nxt    = '0;
                w_idx_nxt    = '0;
                w_stop_nxt   = 1'b0;
                w_serial_nxt = 1'b1;
                w_active_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_data     <= '0;
            r_shift    <= '0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_data     <= w_data_nxt;
            r_shift    <= w_shift_nxt;
            r_serial   <= w_serial_nxt;
            r_active   <= w_active_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign o_tx_ready  = w_ready;
    assign o_tx_active = r_active;
    assign o_tx_serial = r_serial;
    assign o_tx_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Three transmitter variants (8N1, 7E1, 8O2) driven by one random
//           stimulus stream and compared each cycle against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int C  = 4;
    localparam int FD = 4;
`ifdef UART_TX_FIFO_EN
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       r_dv = 1'b0;
    logic [8:0] r_byte = '0;

    logic w_rdy [3];
    logic w_act [3];
    logic w_ser [3];
    logic w_don [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)) u_dut0 (
        .i_clk(clk), .i_rst(r_rst), .i_tx_dv(r_dv), .i_tx_byte(r_byte[7:0]),
        .o_tx_ready(w_rdy[0]), .o_tx_active(w_act[0]), .o_tx_serial(w_ser[0]), .o_tx_done(w_don[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FD)) u_dut1 (
        .i_clk(clk), .i_rst(r_rst), .i_tx_dv(r_dv), .i_tx_byte(r_byte[6:0]),
        .o_tx_ready(w_rdy[1]), .o_tx_active(w_act[1]), .o_tx_serial(w_ser[1]), .o_tx_done(w_don[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(FD)) u_dut2 (
        .i_clk(clk), .i_rst(r_rst), .i_tx_dv(r_dv), .i_tx_byte(r_byte[7:0]),
        .o_tx_ready(w_rdy[2]), .o_tx_active(w_act[2]), .o_tx_serial(w_ser[2]), .o_tx_done(w_don[2]));

    // ---- reference model: a frame is a list of bits, each held C clocks ----
    int         m_pos  [3];   // clocks into current frame, -1 when no frame
    logic [8:0] m_cur  [3];
    bit         m_done [3];
    logic [8:0] m_fq   [3][$];

    function automatic int db(int k);  return (k == 1) ? 7 : 8;             endfunction
    function automatic int par(int k); return (k == 0) ? 0 : (k == 1) ? 2 : 1; endfunction
    function automatic int sb(int k);  return (k == 2) ? 2 : 1;             endfunction
    function automatic int flen(int k);
        return (1 + db(k) + ((par(k) != 0) ? 1 : 0) + sb(k)) * C;
    endfunction
    function automatic logic [8:0] mask(int k, logic [8:0] b);
        return b & 9'((1 << db(k)) - 1);
    endfunction

    function automatic logic frame_bit(int k, logic [8:0] b, int i);
        if (i == 0)                             return 1'b0;
        if (i <= db(k))                         return b[i-1];
        if (par(k) != 0 && i == db(k) + 1)      return (^b) ^ (par(k) == 1);
        return 1'b1;
    endfunction

    function automatic logic m_ready(int k);
        if (FIFO_MODE) return m_fq[k].size() < FD;
        return m_pos[k] < 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic rdy_pre;
            rdy_pre   = m_ready(k);
            m_done[k] = 1'b0;
            if (r_rst) begin
                m_pos[k] = -1;
                m_fq[k].delete();
            end else begin
                if (m_pos[k] >= 0) begin
                    m_pos[k]++;
                    if (m_pos[k] == flen(k)) begin
                        m_pos[k]  = -1;
                        m_done[k] = 1'b1;
                    end
                end else if (FIFO_MODE) begin
                    if (m_fq[k].size() > 0) begin
                        m_cur[k] = m_fq[k].pop_front();
                        m_pos[k] = 0;
                    end
                end else if (r_dv) begin
                    m_cur[k] = mask(k, r_byte);
                    m_pos[k] = 0;
                end
                if (FIFO_MODE && r_dv && rdy_pre) m_fq[k].push_back(mask(k, r_byte));
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic tick(input logic dv, input logic [8:0] b, input logic rst);
        r_dv   = dv;
        r_byte = b;
        r_rst  = rst;
        @(posedge clk);
        model_step();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("serial%0d", k), 32'(w_ser[k]),
                  32'((m_pos[k] < 0) ? 1'b1 : frame_bit(k, m_cur[k], m_pos[k] / C)));
            check($sformatf("active%0d", k), 32'(w_act[k]), 32'(m_pos[k] >= 0));
            check($sformatf("done%0d", k),   32'(w_don[k]), 32'(m_done[k]));
            check($sformatf("ready%0d", k),  32'(w_rdy[k]), 32'(m_ready(k)));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 9'(i), 1'b0);
    endtask

    // Hold a byte on the bus until variant 0 takes it, with a cycle bound.
    task automatic send(input logic [8:0] b);
        int guard;
        guard = 0;
        while (!m_ready(0) && guard < 200) begin
            tick(1'b1, b, 1'b0);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got ready=0 after 200 clk, required ready=1");
        end
        tick(1'b1, b, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_pos[k]  = -1;
            m_cur[k]  = '0;
            m_done[k] = 1'b0;
        end
        tick(1'b0, 9'h0, 1'b1);
        tick(1'b0, 9'h0, 1'b1);
        idle(2);

        send(9'h0A5);              idle(60);
        send(9'h041);              idle(60);
        send(9'h000);              idle(60);
        send(9'h03C);              idle(9);
        tick(1'b1, 9'h0FF, 1'b0);  idle(60);

        send(9'h0C3);              idle(17);     // reset lands inside data bit 3
        tick(1'b0, 9'h0, 1'b1);
        send(9'h05A);              idle(60);

        for (int i = 1; i <= 5; i++) send(9'(8'h11 * i));
        idle(300);

        for (int i = 0; i < 250; i++) tick(1'b1, 9'($urandom), 1'b0);
        idle(60);

        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 2) == 0, 9'($urandom), $urandom_range(0, 299) == 0);
        idle(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
